hack_memory_bus: RTL

- Data-memory stage directly downstream of the Hack CPU.
- Consumes the CPU's address_m, out_m and write_m; returns in_m and drives the CPU hold input.
- Decodes the Hack address map (RAM, screen, keyboard) onto synchronous block RAMs with READ_LATENCY-cycle reads.
- Keeps a one-entry read buffer and stalls the CPU via hold until the buffered word matches address_m.

---
 rtl/hack_memory_bus_pkg.sv | 27 ++
 rtl/hack_memory_bus_if.sv | 42 ++++
 rtl/hack_memory_bus_addr_decode.sv | 28 ++
 rtl/hack_memory_bus.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/hack_memory_bus_pkg.sv
// +--------------------------------------------------------------------------+
// | hack_mem_pkg : Hack data-memory map constants, region and state types    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE    = 15'h0000;
  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_SCREEN = 2'd1,
    REG_KBD    = 2'd2,
    REG_NONE   = 2'd3
  } region_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hack_memory_bus_if.sv
// +--------------------------------------------------------------------------+
// | hack_memory_bus_if : CPU data port plus RAM/screen/keyboard side signals |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface hack_memory_bus_if;

  logic [14:0] address_m;
  logic [15:0] out_m;
  logic        write_m;
  logic [15:0] in_m;
  logic        hold;

  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;

  logic [12:0] screen_addr;
  logic [15:0] screen_wdata;
  logic        screen_we;
  logic [15:0] screen_rdata;

  logic [15:0] keyboard;

  // Environment side: CPU, block RAMs and keyboard
  modport master (
    output address_m, out_m, write_m, ram_rdata, screen_rdata, keyboard,
    input  in_m, hold, ram_addr, ram_wdata, ram_we,
           screen_addr, screen_wdata, screen_we
  );

  modport slave (
    input  address_m, out_m, write_m, ram_rdata, screen_rdata, keyboard,
    output in_m, hold, ram_addr, ram_wdata, ram_we,
           screen_addr, screen_wdata, screen_we
  );

endinterface

`default_nettype wire

// File: rtl/hack_memory_bus_addr_decode.sv
// +--------------------------------------------------------------------------+
// | hack_addr_decode : combinational Hack address -> memory region           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hack_addr_decode
  import hack_mem_pkg::*;
(
  input  logic [14:0] i_addr,
  output region_e     o_region
);

  always_comb begin
    if (i_addr < SCREEN_BASE) begin
      o_region = REG_RAM;
    end else if (i_addr < KBD_ADDR) begin
      o_region = REG_SCREEN;
    end else if (i_addr == KBD_ADDR) begin
      o_region = REG_KBD;
    end else begin
      o_region = REG_NONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hack_memory_bus.sv
// +--------------------------------------------------------------------------+
// | hack_memory_bus : Hack data-memory stage, one-entry read buffer + hold   |
// | Optional macro HACK_MEMBUS_BYPASS_EN forwards rdata in the final wait.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hack_memory_bus
  import hack_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  hack_memory_bus_if.slave bus
);

  localparam logic [2:0] c_LAT = 3'(READ_LATENCY);

  state_e      r_state,      w_state_nxt;
  logic [2:0]  r_cnt,        w_cnt_nxt;
  logic [14:0] r_fetch_addr, w_fetch_addr_nxt;
  logic [14:0] r_buf_addr,   w_buf_addr_nxt;
  logic        r_buf_valid,  w_buf_valid_nxt;
  logic [15:0] r_buf_data,   w_buf_data_nxt;

  region_e     w_region;
  region_e     w_fetch_region;
  logic        w_is_mem;
  logic        w_hit;
  logic        w_addr_match;
  logic        w_final;
  logic        w_ram_we;
  logic        w_screen_we;
  logic        w_write;
  logic [15:0] w_sel_rdata;
  logic [15:0] w_in_m;
  logic        w_hold;

  hack_addr_decode u_addr_decode (
    .i_addr   (bus.address_m),
    .o_region (w_region)
  );

  hack_addr_decode u_fetch_decode (
    .i_addr   (r_fetch_addr),
    .o_region (w_fetch_region)
  );

  assign w_is_mem     = (w_region == REG_RAM) || (w_region == REG_SCREEN);
  assign w_hit        = r_buf_valid && (r_buf_addr == bus.address_m);
  assign w_addr_match = (r_fetch_addr == bus.address_m);
  assign w_final      = (r_state == ST_WAIT) && w_addr_match && (r_cnt == 3'd1);
  assign w_sel_rdata  = (w_fetch_region == REG_SCREEN) ? bus.screen_rdata : bus.ram_rdata;

  assign w_ram_we    = bus.write_m && (w_region == REG_RAM);
  assign w_screen_we = bus.write_m && (w_region == REG_SCREEN);
  assign w_write     = w_ram_we || w_screen_we;

  assign bus.ram_addr     = bus.address_m[13:0];
  assign bus.ram_wdata    = bus.out_m;
  assign bus.ram_we       = w_ram_we;
  assign bus.screen_addr  = bus.address_m[12:0];
  assign bus.screen_wdata = bus.out_m;
  assign bus.screen_we    = w_screen_we;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_fetch_addr <= 15'd0;
      r_buf_addr   <= 15'd0;
      r_buf_valid  <= 1'b0;
      r_buf_data   <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_buf_addr   <= w_buf_addr_nxt;
      r_buf_valid  <= w_buf_valid_nxt;
      r_buf_data   <= w_buf_data_nxt;
    end
  end

  always_comb begin : p_next
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_fetch_addr_nxt = r_fetch_addr;
    w_buf_addr_nxt   = r_buf_addr;
    w_buf_valid_nxt  = r_buf_valid;
    w_buf_data_nxt   = r_buf_data;

    case (r_state)
      ST_IDLE: begin
        if (w_write) begin
          w_buf_valid_nxt = 1'b1;
          w_buf_addr_nxt  = bus.address_m;
          w_buf_data_nxt  = bus.out_m;
        end else if (w_is_mem && !w_hit) begin
          w_state_nxt      = ST_WAIT;
          w_cnt_nxt        = c_LAT;
          w_fetch_addr_nxt = bus.address_m;
        end
      end

      ST_WAIT: begin
        if (w_write) begin
          // A write fills the buffer with the CPU's own word, so the fetch is moot
          w_buf_valid_nxt = 1'b1;
          w_buf_addr_nxt  = bus.address_m;
          w_buf_data_nxt  = bus.out_m;
          w_state_nxt     = ST_IDLE;
        end else if (!w_is_mem) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_addr_match) begin
          w_cnt_nxt        = c_LAT;
          w_fetch_addr_nxt = bus.address_m;
        end else if (r_cnt == 3'd1) begin
          w_buf_valid_nxt = 1'b1;
          w_buf_addr_nxt  = r_fetch_addr;
          w_buf_data_nxt  = w_sel_rdata;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin : p_out
    w_hold = 1'b0;
    w_in_m = 16'h0000;
    case (w_region)
      REG_KBD:  w_in_m = bus.keyboard;
      REG_NONE: w_in_m = 16'h0000;
      default: begin
        w_in_m = r_buf_data;
        w_hold = !((r_state == ST_IDLE) && w_hit);
      end
    endcase
`ifdef HACK_MEMBUS_BYPASS_EN
    if (w_final) begin
      w_hold = 1'b0;
      w_in_m = w_sel_rdata;
    end
`endif
  end

  assign bus.hold = reset_n && w_hold;
  assign bus.in_m = reset_n ? w_in_m : 16'h0000;

endmodule

`default_nettype wire
